// File: rtl/count_bcd_display.sv
// rtl/count_bcd_display.sv - binary to 3-digit BCD converter driving a multiplexed seven-segment display
module count_bcd_display #(
    parameter int REFRESH_DIV    = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  value,
    output logic [11:0] bcd,
    output logic        bcd_valid,
    output logic        busy,
    output logic [6:0]  seg,
    output logic [2:0]  an
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] REFRESH_LAST = CW'(REFRESH_DIV - 1);

    // Reset drive shows a single "0" on the ones digit in the selected polarity.
    localparam logic [6:0] SEG_RESET = SEG_ACTIVE_LOW ? 7'h40 : 7'h3F;
    localparam logic [2:0] AN_RESET  = SEG_ACTIVE_LOW ? 3'b110 : 3'b001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [7:0]  last_value;
    logic [19:0] sreg;
    logic [2:0]  iter;
    logic        start;

    logic [CW-1:0] refresh_cnt;
    logic [1:0]    digit_idx;
    logic [3:0]    digit;
    logic          blank;
    logic [2:0]    an_hi;
    logic [6:0]    seg_hi;

    // One double-dabble step: correct each BCD nibble >= 5, then shift left.
    function automatic logic [19:0] dabble_step(input logic [19:0] r);
        logic [19:0] t;
        t = r;
        for (int n = 0; n < 3; n++) begin
            if (t[8 + 4*n +: 4] >= 4'd5) begin
                t[8 + 4*n +: 4] = t[8 + 4*n +: 4] + 4'd3;
            end
        end
        return {t[18:0], 1'b0};
    endfunction

    // Active-high gfedcba pattern for one BCD digit; non-decimal codes stay dark.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // Converter state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Converter next state: a new value starts a conversion only from IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (value != last_value) state_d = SHIFT;
            SHIFT:   if (iter == 3'd7) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Converter outputs decoded from the state.
    always_comb begin
        busy  = (state_q != IDLE);
        start = (state_q == IDLE) && (value != last_value);
    end

    // Converter datapath: capture, eight shift-add-3 steps, then publish.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_value <= 8'd0;
            sreg       <= 20'd0;
            iter       <= 3'd0;
            bcd        <= 12'd0;
            bcd_valid  <= 1'b0;
        end else begin
            bcd_valid <= 1'b0;
            if (start) begin
                last_value <= value;
                sreg       <= {12'd0, value};
                iter       <= 3'd0;
            end else if (state_q == SHIFT) begin
                sreg <= dabble_step(sreg);
                iter <= iter + 3'd1;
            end else if (state_q == DONE) begin
                bcd       <= sreg[19:8];
                bcd_valid <= 1'b1;
            end
        end
    end

    // Refresh timer: each digit slot lasts REFRESH_DIV cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_cnt <= '0;
            digit_idx   <= 2'd0;
        end else if (refresh_cnt == REFRESH_LAST) begin
            refresh_cnt <= '0;
            digit_idx   <= (digit_idx == 2'd2) ? 2'd0 : digit_idx + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    // Slot selection with leading-zero blanking; ones digit is always lit.
    always_comb begin
        digit = 4'd0;
        blank = 1'b1;
        an_hi = 3'b000;
        case (digit_idx)
            2'd0: begin
                digit = bcd[3:0];
                blank = 1'b0;
                an_hi = 3'b001;
            end
            2'd1: begin
                digit = bcd[7:4];
                blank = (bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0);
                an_hi = 3'b010;
            end
            2'd2: begin
                digit = bcd[11:8];
                blank = (bcd[11:8] == 4'd0);
                an_hi = 3'b100;
            end
            default: begin
                blank = 1'b1;
            end
        endcase
        seg_hi = blank ? 7'h00 : seg_decode(digit);
        if (blank) begin
            an_hi = 3'b000;
        end
    end

    // Registered display drive in the selected polarity.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg <= SEG_RESET;
            an  <= AN_RESET;
        end else begin
            seg <= SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
            an  <= SEG_ACTIVE_LOW ? ~an_hi : an_hi;
        end
    end

endmodule

// File: tb/tb_count_bcd_display.sv
// tb/tb_count_bcd_display.sv - scoreboard bench for count_bcd_display
module tb_count_bcd_display;

    logic        clk;
    logic        rst;
    logic [7:0]  value;
    logic [11:0] bcd;
    logic        bcd_valid;
    logic        busy;
    logic [6:0]  seg;
    logic [2:0]  an;

    int checks = 0;
    int errors = 0;
    int vcount = 0;
    logic [11:0] sb[$];
    logic [11:0] model_bcd = 12'd0;

    int         m_cnt;
    int         m_idx;
    logic [6:0] m_seg;
    logic [2:0] m_an;
    logic [6:0] code_tab [0:9];

    count_bcd_display #(
        .REFRESH_DIV(4),
        .SEG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .value(value),
        .bcd(bcd),
        .bcd_valid(bcd_valid),
        .busy(busy),
        .seg(seg),
        .an(an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference display: slot timer plus blanking, driven by the expected BCD.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt <= 0;
            m_idx <= 0;
            m_an  <= 3'b110;
            m_seg <= 7'h40;
        end else begin
            if (m_idx == 0) begin
                m_an  <= 3'b110;
                m_seg <= ~code_tab[model_bcd[3:0]];
            end else if (m_idx == 1) begin
                if (model_bcd[11:4] == 8'd0) begin
                    m_an  <= 3'b111;
                    m_seg <= 7'h7F;
                end else begin
                    m_an  <= 3'b101;
                    m_seg <= ~code_tab[model_bcd[7:4]];
                end
            end else begin
                if (model_bcd[11:8] == 4'd0) begin
                    m_an  <= 3'b111;
                    m_seg <= 7'h7F;
                end else begin
                    m_an  <= 3'b011;
                    m_seg <= ~code_tab[model_bcd[11:8]];
                end
            end
            if (m_cnt == 3) begin
                m_cnt <= 0;
                m_idx <= (m_idx == 2) ? 0 : m_idx + 1;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    // Scoreboard monitor: pop on every valid pulse, and compare the display.
    always @(negedge clk) begin
        if (rst) begin
            model_bcd = 12'd0;
        end else begin
            if (bcd_valid) begin
                vcount++;
                if (sb.size() == 0) begin
                    chk("unexpected_valid", {20'd0, bcd}, 32'hFFFF);
                end else begin
                    model_bcd = sb.pop_front();
                    chk("sb_bcd", {20'd0, bcd}, {20'd0, model_bcd});
                end
            end
            chk("disp_an", {29'd0, an}, {29'd0, m_an});
            chk("disp_seg", {25'd0, seg}, {25'd0, m_seg});
        end
    end

    task automatic wait_valid(input int target, input string tag);
        int n;
        n = 0;
        while (vcount < target && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(tag, vcount, target);
    endtask

    task automatic drive(input logic [7:0] v);
        @(posedge clk);
        #1 value = v;
    endtask

    initial begin
        int base;
        code_tab[0] = 7'h3F; code_tab[1] = 7'h06; code_tab[2] = 7'h5B;
        code_tab[3] = 7'h4F; code_tab[4] = 7'h66; code_tab[5] = 7'h6D;
        code_tab[6] = 7'h7D; code_tab[7] = 7'h07; code_tab[8] = 7'h7F;
        code_tab[9] = 7'h6F;
        rst   = 1'b1;
        value = 8'd0;

        // 1. Reset, then idle with value 0
        repeat (3) @(posedge clk);
        #1;
        chk("rst_an", {29'd0, an}, 32'h6);
        chk("rst_seg", {25'd0, seg}, 32'h40);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_bcd", {20'd0, bcd}, 32'd0);
            chk("idle_valid", {31'd0, bcd_valid}, 32'd0);
            chk("idle_busy", {31'd0, busy}, 32'd0);
        end

        // 2. 0 -> 255 with exact latency
        drive(8'd255);
        sb.push_back(12'h255);
        @(posedge clk);
        @(negedge clk);
        chk("e0_busy", {31'd0, busy}, 32'd1);
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("e8_busy", {31'd0, busy}, 32'd1);
        chk("e8_valid", {31'd0, bcd_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("e9_valid", {31'd0, bcd_valid}, 32'd1);
        chk("e9_busy", {31'd0, busy}, 32'd0);
        chk("e9_bcd", {20'd0, bcd}, 32'h255);
        @(negedge clk);
        chk("e10_valid", {31'd0, bcd_valid}, 32'd0);
        repeat (30) @(negedge clk);

        // 3. Blanking cases
        drive(8'd7);
        sb.push_back(12'h007);
        wait_valid(2, "cnt_7");
        repeat (28) @(negedge clk);
        drive(8'd105);
        sb.push_back(12'h105);
        wait_valid(3, "cnt_105");
        repeat (28) @(negedge clk);

        // 4. Value change while busy
        base = vcount;
        drive(8'd100);
        sb.push_back(12'h100);
        repeat (3) @(posedge clk);
        #1 value = 8'd42;
        sb.push_back(12'h042);
        repeat (7) @(posedge clk);
        @(negedge clk);
        chk("t4_e9_valid", {31'd0, bcd_valid}, 32'd1);
        chk("t4_e9_bcd", {20'd0, bcd}, 32'h100);
        @(posedge clk);
        @(negedge clk);
        chk("t4_e10_busy", {31'd0, busy}, 32'd1);
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk("t4_e19_valid", {31'd0, bcd_valid}, 32'd1);
        chk("t4_e19_bcd", {20'd0, bcd}, 32'h042);
        repeat (15) @(negedge clk);
        chk("t4_pulses", vcount - base, 2);

        // 5. Reset mid-conversion
        base = vcount;
        drive(8'd200);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        value = 8'd123;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_bcd", {20'd0, bcd}, 32'd0);
        chk("abort_valid", {31'd0, bcd_valid}, 32'd0);
        chk("abort_an", {29'd0, an}, 32'h6);
        chk("abort_seg", {25'd0, seg}, 32'h40);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        sb.push_back(12'h123);
        wait_valid(base + 1, "t5_pulses");
        repeat (20) @(negedge clk);
        chk("t5_bcd", {20'd0, bcd}, 32'h123);

        // 6. Counter wrap 254, 255, 0
        base = vcount;
        drive(8'd254);
        sb.push_back(12'h254);
        repeat (12) @(posedge clk);
        #1 value = 8'd255;
        sb.push_back(12'h255);
        repeat (12) @(posedge clk);
        #1 value = 8'd0;
        sb.push_back(12'h000);
        wait_valid(base + 3, "t6_pulses");
        repeat (20) @(negedge clk);
        chk("t6_bcd", {20'd0, bcd}, 32'h000);
        chk("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/count_bcd_display.md
Name: count_bcd_display

Overview:
- Downstream consumer of the 8-bit up/down counter value.
- Converts the binary count to 3-digit BCD with an iterative shift-add-3 (double-dabble) engine.
- Drives a time-multiplexed 3-digit seven-segment display with leading-zero blanking.
- Also exposes the BCD result and a one-cycle valid strobe to other logic.

Parameters:
- REFRESH_DIV, 50000, clk cycles each digit is displayed; legal values >= 2.
- SEG_ACTIVE_LOW, 1, 1 = seg/an outputs active-low; 0 = active-high.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- value  input  8  binary value to display (counter output)
- bcd  output  12  {hundreds, tens, ones}, 4 bits each
- bcd_valid  output  1  one-cycle pulse when bcd updates
- busy  output  1  high while a conversion is in progress
- seg  output  7  segment drive {g,f,e,d,c,b,a}
- an  output  3  digit enable, one-hot; an[0]=ones, an[1]=tens, an[2]=hundreds

Behaviour:
- Reset (async): FSM=IDLE; last_value=0; bcd=0; bcd_valid=0; busy=0; refresh counter=0; digit index=0.
  - Active-low reset outputs: an=3'b110, seg=7'h40 (shows "0").
  - Active-high reset outputs: an=3'b001, seg=7'h3F.
- Converter FSM: IDLE -> SHIFT -> DONE -> IDLE. busy = (state != IDLE).
  - IDLE: if value != last_value at edge E0, capture value into the shift register and last_value, clear the BCD field, set iteration count=0, go to SHIFT. Otherwise stay in IDLE.
  - SHIFT (edges E1..E8): each edge adds 3 to every BCD nibble >= 5, then shifts the whole {bcd, bin} register left by one. After the 8th shift (E8), go to DONE.
  - DONE (E9): load bcd from the shift register, set bcd_valid=1, go to IDLE.
  - bcd_valid is high for exactly one cycle (E9 to E10).
  - Latency: 9 edges from capture to bcd update.
- value changes while busy are ignored. IDLE re-compares at E10, so a changed value starts a new conversion at E10 with no missed final value.
- Reset during a conversion aborts it: no bcd_valid pulse, bcd=0. After release, a nonzero value converts normally.
- Full range 0..255 is supported. The counter wrapping 255->0 gives bcd=12'h000 on the next conversion.
- Refresh: a counter runs 0..REFRESH_DIV-1. At the terminal count it wraps to 0 and the digit index advances 0->1->2->0.
- seg/an are registered: they reflect the digit index and bcd from the previous edge (one-cycle lag).
- Blanking:
  - Hundreds slot is blanked when hundreds==0.
  - Tens slot is blanked when hundreds==0 and tens==0.
  - Ones is never blanked.
  - A blanked slot drives an all-inactive and seg all-off (active-low: an=3'b111, seg=7'h7F). The slot time is still consumed.
- Segment codes (active-high, gfedcba), inverted when SEG_ACTIVE_LOW=1:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - BCD digits >9 cannot occur; seg=off for them.
- Display and converter run independently. A bcd update mid-slot takes effect on the next edge's registered seg.

Test Plan (REFRESH_DIV=4, SEG_ACTIVE_LOW=1):
1. Reset: hold rst with value=0, then release and run 20 cycles -> bcd=0, bcd_valid never pulses, busy=0, ones slot shows an=3'b110 seg=7'h40, other slots an=3'b111 seg=7'h7F.
2. Value 0->255 applied before edge E0 -> busy high after E0; bcd=12'h255 and one-cycle bcd_valid after E9; busy low after E9; then slots show 5,5,2 (seg 7'h12, 7'h12, 7'h24) with an 110/101/011.
3. Value=7 -> bcd=12'h007; tens and hundreds slots blanked (an=3'b111); ones slot seg=7'h78. Value=105 -> tens slot shows seg=7'h40 (zero not blanked).
4. Value=100 captured at E0, changed to 42 at E3 -> bcd=12'h100 with valid at E9; second conversion starts E10; bcd=12'h042 with valid at E19; exactly two valid pulses.
5. Assert rst at E4 of a conversion of 200 -> immediate busy=0, bcd=0, no valid pulse. Release with value=123 -> a new conversion runs and yields bcd=12'h123.
6. Drive value from a counter stepping 254, 255, 0, with steps spaced 12 cycles apart -> bcd sequence 12'h254, 12'h255, 12'h000 with three valid pulses.
